// File: rtl/pc_branch_sequencer_if.sv
// Control/ALU-to-sequencer bundle: decode qualifiers in, PC, flush and
// branch statistics out.
interface pc_branch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             branch;
    logic             branch_ne;
    logic             zero;
    logic             jump;
    logic [31:0]      imm_offset;
    logic [25:0]      jump_target;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, branch, branch_ne, zero, jump, imm_offset, jump_target,
        input  pc, pc_plus4, flush, branch_cnt, taken_cnt
    );

    modport slave (
        input  stall, branch, branch_ne, zero, jump, imm_offset, jump_target,
        output pc, pc_plus4, flush, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/pc_branch_sequencer.sv
// Program counter owner: resolves BEQ/BNE/J into redirects, holds a
// registered fetch-flush window after each redirect, keeps saturating stats.
module pc_branch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_branch_sequencer_if.slave   bus
);
    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t           state, state_next;
    logic [31:0]      pc_q, pc_next;
    logic [31:0]      pc_plus4;
    logic             flush_q, flush_next;
    logic [2:0]       left_q, left_next;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_next;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_next;
    logic             take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    assign pc_plus4 = pc_q + 32'd4;
    assign take     = (bus.branch & bus.zero) | (bus.branch_ne & ~bus.zero);

    // NOTE: every signal assigned here gets a default first so no latch is
    // inferred when a branch of the case/if tree leaves it untouched.
    always_comb begin
        state_next      = state;
        pc_next         = pc_q;
        flush_next      = flush_q;
        left_next       = left_q;
        branch_cnt_next = branch_cnt_q;
        taken_cnt_next  = taken_cnt_q;
        if (!bus.stall) begin
            pc_next = pc_plus4;
            unique case (state)
                RUN: begin
                    if (bus.branch | bus.branch_ne)
                        branch_cnt_next = sat_inc(branch_cnt_q);
                    if (take) begin
                        pc_next        = pc_plus4 + (bus.imm_offset << 2);
                        taken_cnt_next = sat_inc(taken_cnt_q);
                        state_next     = FLUSH;
                        flush_next     = 1'b1;
                        left_next      = 3'(FLUSH_CYCLES - 1);
                    end else if (bus.jump) begin
                        pc_next    = {pc_plus4[31:28], bus.jump_target, 2'b00};
                        state_next = FLUSH;
                        flush_next = 1'b1;
                        left_next  = 3'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    // Squashed instructions: their control bits are ignored.
                    if (left_q == 3'd0) begin
                        state_next = RUN;
                        flush_next = 1'b0;
                    end else begin
                        left_next = left_q - 3'd1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            pc_q         <= RESET_VECTOR;
            flush_q      <= 1'b0;
            left_q       <= 3'd0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state        <= state_next;
            pc_q         <= pc_next;
            flush_q      <= flush_next;
            left_q       <= left_next;
            branch_cnt_q <= branch_cnt_next;
            taken_cnt_q  <= taken_cnt_next;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.flush      = flush_q;
    assign bus.branch_cnt = branch_cnt_q;
    assign bus.taken_cnt  = taken_cnt_q;
endmodule
